ld_seq: RTL
===========

Name: ld_seq

Overview:
- Parametrised successor to the D extended register: a W-bit datum plus X extension bits.
- Load sources:
  - adder result with carry/extension bits;
  - W-operand, sign-extended;
  - W-operand, zero-extended.
- Adds a multi-cycle shift sequencer (arithmetic right / logical left, one bit per clk_sys) with busy/done handshake and overflow detection.
- Sits beside the ALU; feeds normalisation and multiply/divide step logic.

Parameters:
- W, 8, data width.
- X, 2, extension bits above data (X >= 1).
- CNTW, 4, shift-count width (max shift 2^CNTW-1).

Ports:
- clk_sys  in  1  system clock, all state updates on rising edge
- _rst  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of d, flags, sequencer
- l_d  in  1  load strobe
- src  in  2  load source: 0 sum, 1 w sign-ext, 2 w zero-ext, 3 zero
- sum  in  W  adder result
- sum_x  in  X  adder extension/carry bits, MSB first
- w  in  W  operand
- sh_start  in  1  start shift (one-cycle pulse)
- sh_dir  in  1  0 = left, 1 = arithmetic right
- sh_cnt  in  CNTW  shift count, sampled with sh_start
- d  out  X+W  register, MSB = index X+W-1
- busy  out  1  sequencer shifting
- done  out  1  one-cycle completion pulse
- ovf  out  1  left-shift sign-change flag, sticky
- s  out  1  right-shift sticky bit (see Optional Feature)

Behaviour:
- _rst low (async): d=0, busy=0, done=0, ovf=0, s=0, state IDLE, remaining count=0.
- Per-edge priority: clr > l_d > sh_start > shift step.
- clr: same effect as reset, but synchronous.
- Load (l_d=1): d loads {sum_x,sum}, {X copies of w[W-1],w}, {X zeros,w} or 0 per src.
  - Clears ovf and s.
  - Forces state IDLE; aborts any shift in progress; no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE + sh_start:
  - latch sh_dir; remaining = sh_cnt; clear ovf and s.
  - next state SHIFT if sh_cnt != 0, else DONE.
- SHIFT: busy=1; each edge performs one shift and decrements remaining.
  - Left: d <= {d[X+W-2:0],0}; if d[MSB] != d[MSB-1] before the shift, set ovf.
  - Right: d <= {d[MSB],d[X+W-1:1]}; if d[0]=1 before the shift, set s.
  - On the edge where remaining==1: shift, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
- Latency: sh_start sampled at edge t, count n.
  - busy high during cycles after edges t..t+n-1.
  - Final d valid after edge t+n.
  - done high in the cycle after edge t+n.
  - n=0: done in the cycle after edge t, d unchanged.
- sh_start while in SHIFT or DONE: ignored.
- l_d and sh_start together: load wins; start ignored.
- ovf and s hold until the next load, start, clr or reset.
- Count counts down to 0; no wrap. Shifting past width: left gives 0; right gives all-sign.

Optional Feature:
- LD_SEQ_STICKY_EN defined: s implemented as above (OR of all 1 bits shifted out on right shifts, cleared by load/start/clr/reset).
- Not defined: s port present but tied 0; no sticky register.

Test Plan:
- Reset: _rst low mid-shift (busy=1) -> d=0x000, busy=0, done=0, ovf=0 immediately, without a clock edge.
- src=1, w=0x80, l_d -> d=0x380; then sh_dir=1, sh_cnt=3, sh_start -> busy 3 cycles, d=0x3F0, done one cycle, ovf=0.
- src=0, sum=0x40, sum_x=0, l_d; sh_dir=0, sh_cnt=3 -> d sequence 0x080, 0x100, 0x200; ovf=1 after step 3; done pulses once.
- src=2, w=0xFF -> d=0x0FF; sh_cnt=0 start -> done next cycle, busy never high, d=0x0FF.
- Abort: right shift of 0x3F0 by 5; l_d src=3 at cycle 2 -> d=0x000, busy=0, no done pulse; sh_start during busy ignored.
- src=1, w=0x03, right shift 1 -> d=0x001; s=1 with LD_SEQ_STICKY_EN, s=0 without.

Source files
------------

// File: rtl/ld_seq.sv
// Extended data register (W data + X extension bits) with load muxing and a
// one-bit-per-cycle shift sequencer. Optional sticky bit: LD_SEQ_STICKY_EN.
module ld_seq #(
    parameter int unsigned W    = 8,
    parameter int unsigned X    = 2,
    parameter int unsigned CNTW = 4
) (
    input  logic              clk_sys,
    input  logic              _rst,
    input  logic              clr,
    input  logic              l_d,
    input  logic [1:0]        src,
    input  logic [W-1:0]      sum,
    input  logic [X-1:0]      sum_x,
    input  logic [W-1:0]      w,
    input  logic              sh_start,
    input  logic              sh_dir,
    input  logic [CNTW-1:0]   sh_cnt,
    output logic [X+W-1:0]    d,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic              s
);

    localparam int unsigned DW = X + W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   d_nxt;
    logic [DW-1:0]   load_val;
    logic [CNTW-1:0] rem, rem_nxt;
    logic            dir, dir_nxt;
    logic            ovf_nxt;
`ifdef LD_SEQ_STICKY_EN
    logic            sticky, sticky_nxt;
`endif

    // Load source mux
    always_comb begin
        load_val = '0;
        case (src)
            2'd0:    load_val = {sum_x, sum};
            2'd1:    load_val = {{X{w[W-1]}}, w};
            2'd2:    load_val = {{X{1'b0}}, w};
            default: load_val = '0;
        endcase
    end

    // Next-state and datapath: clr > l_d > sh_start > shift step
    always_comb begin
        state_nxt = state;
        d_nxt     = d;
        rem_nxt   = rem;
        dir_nxt   = dir;
        ovf_nxt   = ovf;
`ifdef LD_SEQ_STICKY_EN
        sticky_nxt = sticky;
`endif
        if (clr) begin
            state_nxt = IDLE;
            d_nxt     = '0;
            rem_nxt   = '0;
            dir_nxt   = 1'b0;
            ovf_nxt   = 1'b0;
`ifdef LD_SEQ_STICKY_EN
            sticky_nxt = 1'b0;
`endif
        end else if (l_d) begin
            state_nxt = IDLE;
            d_nxt     = load_val;
            rem_nxt   = '0;
            ovf_nxt   = 1'b0;
`ifdef LD_SEQ_STICKY_EN
            sticky_nxt = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sh_start) begin
                        dir_nxt   = sh_dir;
                        rem_nxt   = sh_cnt;
                        ovf_nxt   = 1'b0;
`ifdef LD_SEQ_STICKY_EN
                        sticky_nxt = 1'b0;
`endif
                        state_nxt = (sh_cnt != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    if (dir) begin
                        d_nxt = {d[DW-1], d[DW-1:1]};
`ifdef LD_SEQ_STICKY_EN
                        if (d[0]) sticky_nxt = 1'b1;
`endif
                    end else begin
                        d_nxt = {d[DW-2:0], 1'b0};
                        if (d[DW-1] != d[DW-2]) ovf_nxt = 1'b1;
                    end
                    rem_nxt = rem - CNTW'(1);
                    if (rem == CNTW'(1)) state_nxt = DONE;
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and registered outputs; busy/done mirror the next state
    always_ff @(posedge clk_sys or negedge _rst) begin
        if (!_rst) begin
            state <= IDLE;
            d     <= '0;
            rem   <= '0;
            dir   <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef LD_SEQ_STICKY_EN
            sticky <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            d     <= d_nxt;
            rem   <= rem_nxt;
            dir   <= dir_nxt;
            ovf   <= ovf_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
`ifdef LD_SEQ_STICKY_EN
            sticky <= sticky_nxt;
`endif
        end
    end

`ifdef LD_SEQ_STICKY_EN
    assign s = sticky;
`else
    assign s = 1'b0;
`endif

endmodule
